// File: rtl/vote_capture_ctrl.sv
// Debounced single-candidate vote capture with a one-vote-per-voter registry.
// Issues one-cycle accept/reject pulses and tracks the number of distinct voters accepted.
module vote_capture_ctrl #(
    parameter int unsigned N_CAND   = 4,
    parameter int unsigned VOTER_W  = 8,
    parameter int unsigned DEBOUNCE = 25000000,
    localparam int unsigned CW      = (N_CAND > 2) ? $clog2(N_CAND) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic               pollsig,
    input  logic [N_CAND-1:0]  buttons,
    input  logic [VOTER_W-1:0] voter_id,
    input  logic               clear_voted,
    output logic               vote_valid,
    output logic [CW-1:0]      vote_cand,
    output logic               vote_reject,
    output logic               busy,
    output logic [VOTER_W:0]   voted_count
);

    localparam int unsigned CNT_W    = $clog2(DEBOUNCE);
    localparam int unsigned N_VOTERS = 2 ** VOTER_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CNT_W-1:0]     r_cnt;
    logic [CW-1:0]        r_cand;
    logic [VOTER_W-1:0]   r_id;
    logic [N_VOTERS-1:0]  r_voted;
    logic                 r_vote_valid;
    logic                 r_vote_reject;
    logic [CW-1:0]        r_vote_cand;
    logic                 r_busy;
    logic [VOTER_W:0]     r_voted_count;

    logic                 w_enable;
    logic                 w_onehot;
    logic                 w_held;
    logic                 w_at_max;
    logic [CW-1:0]        w_btn_idx;

    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [CW-1:0]        w_cand_nxt;
    logic [VOTER_W-1:0]   w_id_nxt;
    logic                 w_valid_nxt;
    logic                 w_reject_nxt;
    logic [CW-1:0]        w_vote_cand_nxt;
    logic [VOTER_W:0]     w_voted_count_nxt;
    logic                 w_reg_set;
    logic                 w_reg_clear;
    logic                 w_busy_nxt;

    assign w_enable = pollsig & ~mode;
    assign w_onehot = (buttons != '0) && ((buttons & (buttons - N_CAND'(1))) == '0);
    assign w_held   = (buttons == (N_CAND'(1) << r_cand));
    assign w_at_max = (r_cnt == CNT_W'(DEBOUNCE - 1));

    // Index of the highest set button; only meaningful when w_onehot is true.
    always_comb begin
        w_btn_idx = '0;
        for (int i = 0; i < int'(N_CAND); i++) begin
            if (buttons[i]) begin
                w_btn_idx = CW'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_onehot) begin
                        w_state_nxt = COUNT;
                    end
                end
                COUNT: begin
                    if (!w_held) begin
                        w_state_nxt = IDLE;
                    end else if (w_at_max) begin
                        w_state_nxt = WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (buttons == '0) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Datapath/output next values; the decision fires on the last debounce sample.
    always_comb begin
        w_cnt_nxt         = r_cnt;
        w_cand_nxt        = r_cand;
        w_id_nxt          = r_id;
        w_valid_nxt       = 1'b0;
        w_reject_nxt      = 1'b0;
        w_vote_cand_nxt   = r_vote_cand;
        w_voted_count_nxt = r_voted_count;
        w_reg_set         = 1'b0;
        w_reg_clear       = clear_voted & ~pollsig;
        w_busy_nxt        = (w_state_nxt != IDLE);
        if (!w_enable) begin
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_onehot) begin
                        w_cnt_nxt  = CNT_W'(1);
                        w_cand_nxt = w_btn_idx;
                        w_id_nxt   = voter_id;
                    end
                end
                COUNT: begin
                    if (!w_held) begin
                        w_cnt_nxt = '0;
                    end else if (!w_at_max) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else begin
                        w_vote_cand_nxt = r_cand;
                        if (!r_voted[r_id]) begin
                            w_valid_nxt       = 1'b1;
                            w_reg_set         = 1'b1;
                            w_voted_count_nxt = r_voted_count + (VOTER_W + 1)'(1);
                        end else begin
                            w_reject_nxt = 1'b1;
                        end
                    end
                end
                WAIT_REL: begin
                    if (buttons == '0) begin
                        w_cnt_nxt = '0;
                    end
                end
                default: w_cnt_nxt = '0;
            endcase
        end
        // Clear only happens with the poll closed, so it never meets a decision.
        if (w_reg_clear) begin
            w_voted_count_nxt = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_cand        <= '0;
            r_id          <= '0;
            r_voted       <= '0;
            r_vote_valid  <= 1'b0;
            r_vote_reject <= 1'b0;
            r_vote_cand   <= '0;
            r_busy        <= 1'b0;
            r_voted_count <= '0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_cand        <= w_cand_nxt;
            r_id          <= w_id_nxt;
            r_vote_valid  <= w_valid_nxt;
            r_vote_reject <= w_reject_nxt;
            r_vote_cand   <= w_vote_cand_nxt;
            r_busy        <= w_busy_nxt;
            r_voted_count <= w_voted_count_nxt;
            if (w_reg_clear) begin
                r_voted <= '0;
            end else if (w_reg_set) begin
                r_voted[r_id] <= 1'b1;
            end
        end
    end

    assign vote_valid  = r_vote_valid;
    assign vote_reject = r_vote_reject;
    assign vote_cand   = r_vote_cand;
    assign busy        = r_busy;
    assign voted_count = r_voted_count;

endmodule

// File: tb/tb_vote_capture_ctrl.sv
// Directed bench for vote_capture_ctrl (N_CAND=4, VOTER_W=4, DEBOUNCE=4).
// Expected decisions are queued when a press is driven and popped when a pulse appears.
module tb_vote_capture_ctrl;

    localparam int unsigned N_CAND   = 4;
    localparam int unsigned VOTER_W  = 4;
    localparam int unsigned DEBOUNCE = 4;

    typedef struct packed {
        logic       rej;
        logic [1:0] cand;
        logic [4:0] cnt;
    } exp_t;

    logic               clock;
    logic               reset;
    logic               mode;
    logic               pollsig;
    logic [N_CAND-1:0]  buttons;
    logic [VOTER_W-1:0] voter_id;
    logic               clear_voted;
    logic               vote_valid;
    logic [1:0]         vote_cand;
    logic               vote_reject;
    logic               busy;
    logic [VOTER_W:0]   voted_count;

    int   n_err = 0;
    int   n_chk = 0;
    exp_t q[$];

    vote_capture_ctrl #(
        .N_CAND   (N_CAND),
        .VOTER_W  (VOTER_W),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .pollsig     (pollsig),
        .buttons     (buttons),
        .voter_id    (voter_id),
        .clear_voted (clear_voted),
        .vote_valid  (vote_valid),
        .vote_cand   (vote_cand),
        .vote_reject (vote_reject),
        .busy        (busy),
        .voted_count (voted_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_vote(input logic rej, input logic [1:0] cand, input logic [4:0] cnt);
        exp_t e;
        e.rej  = rej;
        e.cand = cand;
        e.cnt  = cnt;
        q.push_back(e);
    endtask

    // Hold one press for the given number of samples, release, and expect IDLE afterwards.
    task automatic press(input logic [3:0] btn, input logic [3:0] id, input int hold);
        voter_id = id;
        buttons  = btn;
        step(hold);
        buttons = '0;
        step(1);
        chk("busy_after_release", 32'(busy), 32'd0);
    endtask

    // Scoreboard: every decision pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && (vote_valid || vote_reject)) begin
            chk("no_dual_pulse", 32'(vote_valid & vote_reject), 32'd0);
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $error("FAIL unexpected_pulse observed valid=%0b reject=%0b expected none",
                       vote_valid, vote_reject);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_reject", 32'(vote_reject), 32'(e.rej));
                chk("pulse_cand", 32'(vote_cand), 32'(e.cand));
                chk("pulse_count", 32'(voted_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        reset       = 1'b1;
        mode        = 1'b0;
        pollsig     = 1'b0;
        buttons     = '0;
        voter_id    = '0;
        clear_voted = 1'b0;
        #12;
        chk("rst_valid", 32'(vote_valid), 32'd0);
        chk("rst_reject", 32'(vote_reject), 32'd0);
        chk("rst_cand", 32'(vote_cand), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(voted_count), 32'd0);
        reset = 1'b0;
        step(1);

        // First vote: latency and single pulse while held.
        pollsig  = 1'b1;
        voter_id = 4'd3;
        buttons  = 4'b0010;
        expect_vote(1'b0, 2'd1, 5'd1);
        step(1);
        chk("s1_busy_k", 32'(busy), 32'd1);
        chk("s1_valid_k", 32'(vote_valid), 32'd0);
        step(2);
        chk("s1_valid_k2", 32'(vote_valid), 32'd0);
        step(1);
        chk("s1_valid_k3", 32'(vote_valid), 32'd1);
        chk("s1_cand_k3", 32'(vote_cand), 32'd1);
        chk("s1_count_k3", 32'(voted_count), 32'd1);
        step(1);
        chk("s1_valid_k4", 32'(vote_valid), 32'd0);
        step(1);
        chk("s1_busy_held", 32'(busy), 32'd1);
        buttons = '0;
        step(1);
        chk("s1_busy_rel", 32'(busy), 32'd0);

        // Repeat voter is rejected, a new voter is accepted.
        expect_vote(1'b1, 2'd1, 5'd1);
        press(4'b0010, 4'd3, 6);
        chk("s2_count_rej", 32'(voted_count), 32'd1);
        expect_vote(1'b0, 2'd3, 5'd2);
        press(4'b1000, 4'd5, 6);
        chk("s2_cand_hold", 32'(vote_cand), 32'd3);

        // Short burst aborts; the full second burst votes.
        voter_id = 4'd7;
        buttons  = 4'b0010;
        step(3);
        buttons = '0;
        step(1);
        chk("s3_abort_busy", 32'(busy), 32'd0);
        expect_vote(1'b0, 2'd1, 5'd3);
        press(4'b0010, 4'd7, 4);

        // Two buttons never start a count; adding a button aborts a count.
        voter_id = 4'd8;
        buttons  = 4'b0011;
        step(5);
        chk("s4_multi_busy_a", 32'(busy), 32'd0);
        step(5);
        chk("s4_multi_busy_b", 32'(busy), 32'd0);
        buttons = '0;
        step(1);
        buttons = 4'b0001;
        step(2);
        chk("s4_single_busy", 32'(busy), 32'd1);
        buttons = 4'b0011;
        step(1);
        chk("s4_added_busy", 32'(busy), 32'd0);
        step(4);
        buttons = '0;
        step(1);

        // Disabling mid-count discards the press.
        voter_id = 4'd9;
        buttons  = 4'b0100;
        step(2);
        mode = 1'b1;
        step(1);
        chk("s5_mode_busy", 32'(busy), 32'd0);
        step(4);
        buttons = '0;
        step(1);
        mode    = 1'b0;
        buttons = 4'b0100;
        step(2);
        pollsig = 1'b0;
        step(1);
        chk("s5_poll_busy", 32'(busy), 32'd0);
        step(4);
        buttons = '0;
        step(1);
        pollsig = 1'b1;

        // Registry clear is gated by the poll being closed.
        clear_voted = 1'b1;
        step(1);
        clear_voted = 1'b0;
        chk("s5_clear_open", 32'(voted_count), 32'd3);
        pollsig     = 1'b0;
        clear_voted = 1'b1;
        step(1);
        clear_voted = 1'b0;
        chk("s5_clear_closed", 32'(voted_count), 32'd0);
        pollsig = 1'b1;
        expect_vote(1'b0, 2'd1, 5'd1);
        press(4'b0010, 4'd3, 5);

        // Asynchronous reset between edges during COUNT.
        voter_id = 4'd10;
        buttons  = 4'b0001;
        step(2);
        chk("s6_busy_pre", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_cand", 32'(vote_cand), 32'd0);
        chk("s6_rst_count", 32'(voted_count), 32'd0);
        chk("s6_rst_valid", 32'(vote_valid), 32'd0);
        buttons = '0;
        #3;
        reset = 1'b0;
        step(2);

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
